// File: rtl/key_sw_conditioner.sv
// rtl/key_sw_conditioner.sv - synchronise, debounce and event-encode pad buttons and DIP switches
module key_sw_conditioner #(
  parameter int         DEB_CYCLES    = 2_000_000,
  parameter int         REPEAT_DELAY  = 50_000_000,
  parameter int         REPEAT_PERIOD = 15_000_000,
  parameter logic [3:0] REPEAT_MASK   = 4'b0100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_raw,
  input  logic [4:0] sw_raw,
  output logic [3:0] key_evt_n,
  output logic [3:0] key_level_n,
  output logic [4:0] sw_stable,
  output logic       sw_change
);

  // Keys occupy bits [3:0] and switches bits [8:4] of every per-bit vector;
  // keys idle high (released), switches idle low.
  localparam int            NB       = 9;
  localparam logic [NB-1:0] RST_VAL  = 9'b0_0000_1111;
  localparam int            CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int            HC_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            HC_W     = (HC_MAX > 1) ? $clog2(HC_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [HC_W-1:0]  DELAY_LAST  = HC_W'(REPEAT_DELAY - 1);
  localparam logic [HC_W-1:0]  PERIOD_LAST = HC_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_DELAY = 2'd1,
    R_RPT   = 2'd2
  } rpt_state_t;

  logic [NB-1:0]    r_sync1;
  logic [NB-1:0]    r_sync2;
  logic [NB-1:0]    r_stable;
  logic [CNT_W-1:0] r_cnt [0:NB-1];
  logic [NB-1:0]    w_upd;
  logic [3:0]       w_press;
  logic [3:0]       w_rel;

  rpt_state_t       r_rs [0:3];
  logic [HC_W-1:0]  r_hc [0:3];
  logic [3:0]       r_evt_n;
  logic             r_sw_change;

  // Two-flop synchroniser per pad bit, then per-bit stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= RST_VAL;
      r_sync2  <= RST_VAL;
      r_stable <= RST_VAL;
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= {sw_raw, key_raw};
      r_sync2 <= r_sync1;
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Flags the bits whose debounced level flips at the coming edge.
  always_comb begin
    w_upd = '0;
    for (int i = 0; i < NB; i++) begin
      w_upd[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  assign w_press = w_upd[3:0] &  r_stable[3:0];
  assign w_rel   = w_upd[3:0] & ~r_stable[3:0];

  // Per-key press event and hold/auto-repeat state machine; release always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_n <= 4'hF;
      for (int i = 0; i < 4; i++) begin
        r_rs[i] <= R_IDLE;
        r_hc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_evt_n[i] <= 1'b1;
        if (w_press[i]) begin
          r_evt_n[i] <= 1'b0;
          r_hc[i]    <= '0;
          if (REPEAT_MASK[i]) r_rs[i] <= R_DELAY;
        end else if (w_rel[i]) begin
          r_rs[i] <= R_IDLE;
          r_hc[i] <= '0;
        end else begin
          case (r_rs[i])
            R_DELAY: begin
              if (r_hc[i] == DELAY_LAST) begin
                r_evt_n[i] <= 1'b0;
                r_rs[i]    <= R_RPT;
                r_hc[i]    <= '0;
              end else begin
                r_hc[i] <= r_hc[i] + 1'b1;
              end
            end
            R_RPT: begin
              if (r_hc[i] == PERIOD_LAST) begin
                r_evt_n[i] <= 1'b0;
                r_hc[i]    <= '0;
              end else begin
                r_hc[i] <= r_hc[i] + 1'b1;
              end
            end
            default: begin
              r_rs[i] <= R_IDLE;
              r_hc[i] <= '0;
            end
          endcase
        end
      end
    end
  end

  // One strobe whenever any switch level updates, however many bits move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sw_change <= 1'b0;
    else        r_sw_change <= |w_upd[8:4];
  end

  assign key_evt_n   = r_evt_n;
  assign key_level_n = r_stable[3:0];
  assign sw_stable   = r_stable[8:4];
  assign sw_change   = r_sw_change;

endmodule

// File: tb/tb_key_sw_conditioner.sv
// tb/tb_key_sw_conditioner.sv - scoreboard bench for key_sw_conditioner
module tb_key_sw_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_raw;
  logic [4:0] sw_raw;
  logic [3:0] key_evt_n;
  logic [3:0] key_level_n;
  logic [4:0] sw_stable;
  logic       sw_change;

  key_sw_conditioner #(
    .DEB_CYCLES   (4),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(8),
    .REPEAT_MASK  (4'b0100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .sw_raw     (sw_raw),
    .key_evt_n  (key_evt_n),
    .key_level_n(key_level_n),
    .sw_stable  (sw_stable),
    .sw_change  (sw_change)
  );

  typedef struct {
    int         cyc;
    logic [8:0] val;
  } exp_t;

  exp_t exp_evt[$];
  exp_t exp_sw[$];
  exp_t e_k;
  exp_t e_s;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n0;
  int m0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_evt(input int c, input logic [3:0] v);
    exp_t x;
    x.cyc = c;
    x.val = {5'd0, v};
    exp_evt.push_back(x);
  endtask

  task automatic push_sw(input int c, input logic [4:0] v);
    exp_t x;
    x.cyc = c;
    x.val = {4'd0, v};
    exp_sw.push_back(x);
  endtask

  // Scoreboard: every observed event or strobe must match the head of its queue.
  always @(negedge clk) begin
    if (key_evt_n !== 4'hF) begin
      if (exp_evt.size() == 0) begin
        chk("evt_unexpected", {28'd0, key_evt_n}, 32'hF);
      end else begin
        e_k = exp_evt.pop_front();
        chk("evt_cycle", cyc, e_k.cyc);
        chk("evt_value", {28'd0, key_evt_n}, {23'd0, e_k.val});
      end
    end
    if (sw_change !== 1'b0) begin
      if (exp_sw.size() == 0) begin
        chk("sw_change_unexpected", {31'd0, sw_change}, 32'd0);
      end else begin
        e_s = exp_sw.pop_front();
        chk("sw_change_cycle", cyc, e_s.cyc);
        chk("sw_change_value", {27'd0, sw_stable}, {23'd0, e_s.val});
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    key_raw = 4'hF;
    sw_raw  = 5'd0;
    tick(3);
    chk("rst_evt",    {28'd0, key_evt_n},   32'hF);
    chk("rst_level",  {28'd0, key_level_n}, 32'hF);
    chk("rst_sw",     {27'd0, sw_stable},   32'd0);
    chk("rst_change", {31'd0, sw_change},   32'd0);
    rst_n = 1'b1;

    // Idle pads: nothing may happen.
    tick(50);
    chk("idle_level", {28'd0, key_level_n}, 32'hF);
    chk("idle_sw",    {27'd0, sw_stable},   32'd0);

    // Single clean press on key 0, then release.
    n0 = cyc;
    key_raw[0] = 1'b0;
    push_evt(n0 + 6, 4'b1110);
    tick(30);
    chk("k0_level_pressed", {31'd0, key_level_n[0]}, 32'd0);
    key_raw[0] = 1'b1;
    n0 = cyc;
    tick(5);
    chk("k0_level_before_release", {31'd0, key_level_n[0]}, 32'd0);
    tick(1);
    chk("k0_level_released", {31'd0, key_level_n[0]}, 32'd1);
    tick(10);
    chk("k0_queue_empty", exp_evt.size(), 32'd0);

    // Bouncing key 1: only the final settled press counts.
    n0 = cyc;
    key_raw[1] = 1'b0; tick(1);
    key_raw[1] = 1'b1; tick(1);
    key_raw[1] = 1'b0; tick(1);
    key_raw[1] = 1'b1; tick(1);
    key_raw[1] = 1'b0;
    push_evt(n0 + 10, 4'b1101);
    tick(30);
    key_raw[1] = 1'b1;
    tick(12);
    chk("k1_queue_empty", exp_evt.size(), 32'd0);

    // Key 2 held: press event then auto-repeat; release coincides with a would-be repeat.
    n0 = cyc;
    key_raw[2] = 1'b0;
    push_evt(n0 + 6,  4'b1011);
    push_evt(n0 + 26, 4'b1011);
    push_evt(n0 + 34, 4'b1011);
    push_evt(n0 + 42, 4'b1011);
    push_evt(n0 + 50, 4'b1011);
    push_evt(n0 + 58, 4'b1011);
    tick(60);
    key_raw[2] = 1'b1;
    tick(25);
    chk("k2_queue_empty", exp_evt.size(), 32'd0);
    chk("k2_level_released", {31'd0, key_level_n[2]}, 32'd1);

    // Key 3 held without repeat enabled.
    n0 = cyc;
    key_raw[3] = 1'b0;
    push_evt(n0 + 6, 4'b0111);
    tick(60);
    key_raw[3] = 1'b1;
    tick(12);
    chk("k3_queue_empty", exp_evt.size(), 32'd0);

    // Keys 0 and 1 together.
    n0 = cyc;
    key_raw[1:0] = 2'b00;
    push_evt(n0 + 6, 4'b1100);
    tick(12);
    chk("k01_level", {28'd0, key_level_n}, 32'hC);
    key_raw[1:0] = 2'b11;
    tick(12);
    chk("k01_queue_empty", exp_evt.size(), 32'd0);

    // Switch change, then a short pulse that must be rejected.
    n0 = cyc;
    sw_raw = 5'b10110;
    push_sw(n0 + 6, 5'b10110);
    tick(15);
    chk("sw_settled", {27'd0, sw_stable}, 32'h16);
    sw_raw = 5'b00001;
    tick(2);
    sw_raw = 5'b10110;
    tick(15);
    chk("sw_pulse_rejected", {27'd0, sw_stable}, 32'h16);
    chk("sw_queue_empty", exp_sw.size(), 32'd0);

    // Reset in the middle of a key 2 hold.
    n0 = cyc;
    key_raw[2] = 1'b0;
    push_evt(n0 + 6,  4'b1011);
    push_evt(n0 + 26, 4'b1011);
    tick(30);
    rst_n = 1'b0;
    exp_evt.delete();
    #1;
    chk("midrst_evt",    {28'd0, key_evt_n},   32'hF);
    chk("midrst_level",  {28'd0, key_level_n}, 32'hF);
    chk("midrst_sw",     {27'd0, sw_stable},   32'd0);
    chk("midrst_change", {31'd0, sw_change},   32'd0);
    tick(3);
    m0 = cyc;
    rst_n = 1'b1;
    push_evt(m0 + 6,  4'b1011);
    push_sw (m0 + 6,  5'b10110);
    push_evt(m0 + 26, 4'b1011);
    push_evt(m0 + 34, 4'b1011);
    push_evt(m0 + 42, 4'b1011);
    tick(40);
    key_raw[2] = 1'b1;
    tick(20);
    chk("post_rst_evt_queue_empty", exp_evt.size(), 32'd0);
    chk("post_rst_sw_queue_empty",  exp_sw.size(),  32'd0);
    chk("post_rst_sw",              {27'd0, sw_stable}, 32'h16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_sw_conditioner.md
Name: key_sw_conditioner

Overview:
- Front-end conditioning stage between the board pins (4 push-buttons, 5 DIP switches) and the top-level control FSM.
- Synchronises and debounces every input.
- Converts each button press into a single-cycle, active-low event; the FSM's `key` port therefore sees one press as exactly one cycle.
- Optional auto-repeat on selected keys (browse/next). Debounced switch levels are exported together with a change strobe.

Parameters:
- DEB_CYCLES, 2_000_000: consecutive stable cycles needed to accept a new key/switch level (20 ms at 100 MHz); must be ≥2.
- REPEAT_DELAY, 50_000_000: cycles from accepted press to first auto-repeat event (500 ms).
- REPEAT_PERIOD, 15_000_000: cycles between subsequent auto-repeat events (150 ms).
- REPEAT_MASK, 4'b0100: per-key auto-repeat enable; bit i=1 enables repeat on key i.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  reset, asynchronous, active-low
- key_raw  in  4  pad buttons, active-low (0 = pressed), asynchronous
- sw_raw  in  5  pad DIP switches, asynchronous
- key_evt_n  out  4  press events, active-low, one cycle per event; feeds FSM key
- key_level_n  out  4  debounced button levels, active-low
- sw_stable  out  5  debounced switch levels; feeds FSM sw
- sw_change  out  1  one-cycle strobe when any sw_stable bit changes

Behaviour:
- Reset values:
  - key sync flops = 1; sw sync flops = 0.
  - key_level_n = 4'b1111; key_evt_n = 4'b1111.
  - sw_stable = 5'b0; sw_change = 0.
  - All counters = 0.
  - Reset asserted mid-count or mid-hold aborts everything: no event is emitted during or after reset until a fresh press is accepted.
- Synchroniser: 2-flop chain per bit. s = output of the 2nd flop. Pad-to-s latency is 2 cycles.
- Debounce, per bit, independent counter cnt of width clog2(DEB_CYCLES):
  - If s == stable: cnt <= 0.
  - Else if cnt == DEB_CYCLES-1: stable <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Timing: s first differs in cycle t0 → stable updates at the edge ending cycle t0+DEB_CYCLES-1 (visible at cycle t0+DEB_CYCLES).
  - Any glitch returning s to stable before that point restarts the count from 0.
- Key press event:
  - When key_level_n[i] goes 1→0, key_evt_n[i] = 0 for exactly that one cycle (same cycle the new level is visible).
  - Release (0→1) produces no event.
  - End-to-end latency, pad edge to event: 2 + DEB_CYCLES cycles.
- Auto-repeat, per key with REPEAT_MASK[i]=1. Per-key hold counter hc and state rs:
  - States: R_IDLE (released), R_DELAY (waiting for first repeat), R_RPT (periodic).
  - Press event: rs=R_DELAY, hc=0.
  - R_DELAY: hc reaches REPEAT_DELAY-1 → repeat event (key_evt_n[i]=0 for one cycle), rs=R_RPT, hc=0.
  - R_RPT: hc reaches REPEAT_PERIOD-1 → repeat event, hc=0.
  - Debounced release in any state: rs=R_IDLE, hc=0 that cycle, and no event that cycle.
  - Keys with mask bit 0 stay in R_IDLE and never repeat.
- Simultaneous keys: each bit is independent, so multiple key_evt_n bits may be 0 in the same cycle. Priority between them is resolved downstream; this block does no arbitration.
- Switches:
  - Same debounce per bit.
  - sw_change = 1 for one cycle in any cycle where at least one sw_stable bit updates.
  - Several bits updating in the same cycle → a single strobe.
  - After reset, a nonzero pad setting settles after 2+DEB_CYCLES cycles and produces one sw_change. This is intended.
- All outputs are registered. No combinational path from pad to output.

Test Plan:
(Bench uses DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, REPEAT_MASK=4'b0100.)
- Reset, all pads idle (key_raw=1111, sw_raw=0) for 50 cycles → key_evt_n=1111, key_level_n=1111, sw_stable=0, sw_change never 1.
- key_raw[0] driven 0 and held 30 cycles → key_level_n[0]=0 and key_evt_n[0]=0 exactly once, 6 cycles after the pad edge (±1 for pad-to-clk alignment). Release → no event; level returns to 1 after 6 cycles.
- key_raw[1] bounce pattern 0,1,0,1 (one cycle each), then 0 held → a single event, timed from the last 1→0; no event from the bounces.
- key_raw[2] held 60 cycles → events at press (+6), then +20, +28, +36, +44, +52 from the press event. Release → repeats stop.
- key_raw[3] held 60 cycles (mask 0) → exactly one event.
- key_raw[0] and key_raw[1] pressed in the same cycle → key_evt_n=1100 in one cycle.
- sw_raw 0→5'b10110, held → sw_stable=5'b10110 after 6 cycles with a single sw_change pulse.
- sw_raw pulses to 5'b00001 for 2 cycles → no change.
- rst_n asserted during key_raw[2] hold → outputs return to reset values immediately. After rst_n release with key still held → one fresh event after 6 cycles, then the repeat schedule restarts.
